// File: rtl/data_mux.sv
// Write-back source selector: load data, immediate or ALU result, registered once before the register file.
// Optional DATA_MUX_PARITY_EN adds a registered parity bit (regD_par) alongside regD.
module data_mux #(
  parameter int         WIDTH       = 16,
  parameter logic [3:0] LOAD_OPCODE = 4'hA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] imm_out,
  input  logic [WIDTH-1:0] rd_data_bus,
  input  logic             imm_en,
  input  logic [3:0]       op_code,
  output logic [WIDTH-1:0] regD,
  output logic [1:0]       regD_src
`ifdef DATA_MUX_PARITY_EN
  ,
  output logic             regD_par
`endif
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_IMM  = 2'b01;
  localparam logic [1:0] SRC_LOAD = 2'b10;

  logic [WIDTH-1:0] regd_d, regd_q;
  logic [1:0]       src_d, src_q;

  // Load has priority over the immediate; only the chosen bus reaches the flop.
  always_comb begin
    regd_d = alu_out;
    src_d  = SRC_ALU;
    if (op_code == LOAD_OPCODE) begin
      regd_d = rd_data_bus;
      src_d  = SRC_LOAD;
    end else if (imm_en) begin
      regd_d = imm_out;
      src_d  = SRC_IMM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regd_q <= '0;
      src_q  <= SRC_ALU;
    end else begin
      regd_q <= regd_d;
      src_q  <= src_d;
    end
  end

  assign regD     = regd_q;
  assign regD_src = src_q;

`ifdef DATA_MUX_PARITY_EN
  function automatic logic calc_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic par_d, par_q;

  always_comb begin
    par_d = calc_parity(regd_d);
  end

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign regD_par = par_q;
`endif

endmodule

// File: tb/tb_data_mux.sv
// Scoreboard bench for data_mux: expected write-back values are queued on drive and checked one edge later.
module tb_data_mux;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] alu_out, imm_out, rd_data_bus;
  logic             imm_en;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] regD;
  logic [1:0]       regD_src;
`ifdef DATA_MUX_PARITY_EN
  logic             regD_par;
`endif

  data_mux #(.WIDTH(WIDTH), .LOAD_OPCODE(4'hA)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_out     (alu_out),
    .imm_out     (imm_out),
    .rd_data_bus (rd_data_bus),
    .imm_en      (imm_en),
    .op_code     (op_code),
    .regD        (regD),
    .regD_src    (regD_src)
`ifdef DATA_MUX_PARITY_EN
    ,
    .regD_par    (regD_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic             p;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: reset clears, otherwise load opcode 10 beats imm_en, else ALU.
  function automatic exp_t model(input logic r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] i,
                                 input logic [WIDTH-1:0] m, input logic ie, input logic [3:0] op);
    exp_t e;
    if (r)              begin e.d = '0; e.s = 2'd0; end
    else if (op == 4'd10) begin e.d = m;  e.s = 2'd2; end
    else if (ie)        begin e.d = i;  e.s = 2'd1; end
    else                begin e.d = a;  e.s = 2'd0; end
    e.p = r ? 1'b0 : (^e.d);
    return e;
  endfunction

  task automatic drive(input logic r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] i,
                       input logic [WIDTH-1:0] m, input logic ie, input logic [3:0] op);
    rst = r; alu_out = a; imm_out = i; rd_data_bus = m; imm_en = ie; op_code = op;
    exp_q.push_back(model(r, a, i, m, ie, op));
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_regD"}, 32'(regD), 32'(e.d));
      check({tag, "_src"}, 32'(regD_src), 32'(e.s));
`ifdef DATA_MUX_PARITY_EN
      check({tag, "_par"}, 32'(regD_par), 32'(e.p));
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; alu_out = '0; imm_out = '0; rd_data_bus = '0; imm_en = 1'b0; op_code = 4'd0;
    #1;

    // Scenario 1: reset for two edges, then ALU path
    drive(1'b1, 16'd45, 16'd55, 16'd115, 1'b0, 4'd0); tick("rst0");
    drive(1'b1, 16'd45, 16'd55, 16'd115, 1'b0, 4'd0); tick("rst1");
    check("rst_regD_const", 32'(regD), 32'd0);
    check("rst_src_const", 32'(regD_src), 32'd0);
    drive(1'b0, 16'd45, 16'd55, 16'd115, 1'b0, 4'd0); tick("s1_alu");
    check("s1_alu_const", 32'(regD), 32'd45);

    // Scenario 2: immediate selected; old value holds until the edge
    drive(1'b0, 16'd45, 16'd55, 16'd115, 1'b1, 4'd0);
    #2;
    check("s2_hold", 32'(regD), 32'd45);
    tick("s2_imm");
    check("s2_imm_const", 32'(regD), 32'd55);

    // Scenario 3: load beats immediate
    drive(1'b0, 16'd45, 16'd55, 16'd115, 1'b1, 4'd10); tick("s3_load");
    check("s3_src_const", 32'(regD_src), 32'd2);

    // Scenario 4: opcode sweep without immediate
    for (int op = 0; op < 16; op++) begin
      drive(1'b0, 16'd45, 16'd55, 16'd115, 1'b0, 4'(op));
      tick($sformatf("s4_op%0d", op));
    end

    // Scenario 5: one-cycle reset during a load
    drive(1'b1, 16'd45, 16'd55, 16'd115, 1'b0, 4'd10); tick("s5_rst");
    check("s5_rst_const", 32'(regD), 32'd0);
    drive(1'b0, 16'd45, 16'd55, 16'd115, 1'b0, 4'd10); tick("s5_load");
    check("s5_load_const", 32'(regD), 32'd115);

    // Bit-exact pass-through of extreme patterns
    drive(1'b0, 16'hFFFF, 16'h8000, 16'h0001, 1'b0, 4'd3);  tick("edge_alu");
    drive(1'b0, 16'hFFFF, 16'h8000, 16'h0001, 1'b1, 4'd3);  tick("edge_imm");
    drive(1'b0, 16'hFFFF, 16'h8000, 16'h0001, 1'b1, 4'd10); tick("edge_load");

`ifdef DATA_MUX_PARITY_EN
    // Scenario 6: parity of the immediate
    drive(1'b0, 16'd45, 16'h0007, 16'd115, 1'b1, 4'd0); tick("s6_p7");
    check("s6_par7_const", 32'(regD_par), 32'd1);
    drive(1'b0, 16'd45, 16'h0003, 16'd115, 1'b1, 4'd0); tick("s6_p3");
    check("s6_par3_const", 32'(regD_par), 32'd0);
`endif

    // Random mix with occasional resets
    for (int n = 0; n < 40; n++) begin
      drive(($urandom_range(0, 9) == 0), 16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), 4'($urandom));
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
